pipe_stage_skid: RTL and testbench
==================================

# pipe_stage_skid

Parametrised pipeline stage register with valid/ready handshake, a one-entry skid buffer, stall and flush. It is the successor to the fixed-field stage registers (IF/ID through MEM/WB). It replaces per-field registers with a single `DATA_W`-wide payload, so any stage boundary can be built from one block. Back-pressure from the downstream stage stops this stage without a combinational ready path.

## Interface
Parameters:
- `DATA_W`, 32, payload width in bits (packed stage fields: data, ALU result, dst reg, ctrl, PC+imm, ...).
- `CNT_W`, 16, width of performance counters (only used with `PIPE_STAGE_PERF_EN`).

Ports:
- `clk`  in  1  clock; all state updates on the falling edge.
- `rst`  in  1  asynchronous, active-high reset.
- `in_valid`  in  1  upstream presents a payload.
- `in_ready`  out  1  stage can accept; registered.
- `in_data`  in  DATA_W  upstream payload.
- `flush`  in  1  synchronous kill of all held payloads.
- `out_valid`  out  1  `out_data` holds a live payload.
- `out_ready`  in  1  downstream accepts.
- `out_data`  out  DATA_W  payload to downstream; registered.
- `occupancy`  out  2  entries held: 0, 1 or 2.
- `stall_cnt`  out  CNT_W  only with `PIPE_STAGE_PERF_EN`.
- `bubble_cnt`  out  CNT_W  only with `PIPE_STAGE_PERF_EN`.

## Operation
- Handshake events:
  - Accept = `in_valid && in_ready` at a falling edge.
  - Deliver = `out_valid && out_ready` at a falling edge.
- Storage:
  - Output register `out_data` / `out_valid`.
  - Skid register `skid_data` / `skid_valid`.
- States:
  - EMPTY: occupancy 0.
  - BUSY: occupancy 1, output register only.
  - FULL: occupancy 2, output and skid registers.
- `in_ready` = 1 in EMPTY and BUSY, 0 in FULL.
- Transitions when `flush`=0:
  - EMPTY: accept -> load output register, go to BUSY; else stay.
  - BUSY, accept and deliver -> load output register with `in_data`, stay in BUSY.
  - BUSY, accept only -> load skid register, go to FULL.
  - BUSY, deliver only -> EMPTY.
  - BUSY, neither -> hold.
  - FULL: deliver -> output register <= skid register, go to BUSY; else hold. No accept is possible in FULL.
- Flush:
  - Highest priority; clears `out_valid` and `skid_valid`; next state EMPTY.
  - Any accept or deliver in the same edge is discarded.
  - Data registers keep their values (don't-care).
- `out_data` while `out_valid`=0 holds its last value.
- Payload order is strictly FIFO; no payload is duplicated or dropped except by `flush`.
- Reset values:
  - `out_valid`=0, `in_ready`=1, `occupancy`=0.
  - `out_data`=0, skid register=0, counters=0.
  - Reset mid-transfer discards all payloads.

## Timing
- Latency: accept at edge N -> `out_valid`=1 with that payload after edge N (visible for cycle N+1).
- Throughput: one payload per cycle while `out_ready`=1.
- `in_ready` and `out_*` are register outputs; there is no combinational path from `out_ready` to `in_ready`.
- The upstream source must hold `in_data` stable while `in_valid`=1 and `in_ready`=0.
- After `out_ready` deasserts, the stage absorbs at most one further payload (the skid entry). `in_ready` falls after the edge that enters FULL.
- Recovery: from FULL, one deliver restores `in_ready`=1 after that edge.

## Configuration
- `PIPE_STAGE_PERF_EN` defined:
  - `stall_cnt` increments on each edge with `out_valid && !out_ready`.
  - `bubble_cnt` increments on each edge with `!out_valid`.
  - Both saturate at all-ones and are cleared only by `rst` (not by `flush`).
- Not defined: counter ports and logic are absent; behaviour is otherwise identical.

## Test plan
- Streaming: `out_ready`=1, accept 0x11, 0x22, 0x33 on consecutive edges -> `out_data` shows 0x11, 0x22, 0x33 one edge later each; `in_ready` stays 1; occupancy stays 1.
- Back-pressure: `out_ready`=0, offer 0xA, 0xB, 0xC -> 0xA and 0xB accepted, occupancy 2, `in_ready`=0, 0xC held. Raise `out_ready` -> delivers 0xA, 0xB, 0xC in order, with no loss.
- Flush in FULL: state FULL with 0xA/0xB, `flush`=1 with `in_valid`=1 (0xD) -> next cycle occupancy 0, `out_valid`=0, 0xD not delivered.
- Async reset mid-stream: assert `rst` between edges in BUSY -> `out_valid`=0, `out_data`=0, `in_ready`=1 immediately, without waiting for a clock.
- Perf (macro on, `CNT_W`=4): hold `out_valid`=1 and `out_ready`=0 for 20 edges -> `stall_cnt`=15 (saturated).
- Perf (macro on): idle 3 edges after reset -> `bubble_cnt`=3.

Source files
------------

// File: rtl/pipe_stage_skid.sv
// pipe_stage_skid: one pipeline stage boundary with a valid/ready handshake
// and a one-entry skid buffer, so back-pressure never needs a combinational
// path from out_ready to in_ready. All state updates on the falling clock
// edge. An asynchronous active-high reset clears every register.
// Optional performance counters (stall_cnt / bubble_cnt) are built only when
// the macro PIPE_STAGE_PERF_EN is defined.
module pipe_stage_skid #(
  parameter int DATA_W = 32,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [1:0]        occupancy
`ifdef PIPE_STAGE_PERF_EN
  ,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  bubble_cnt
`endif
);

  // State encoding equals the number of held entries.
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    BUSY  = 2'd1,
    FULL  = 2'd2
  } state_t;

  state_t            state, state_next;
  logic [DATA_W-1:0] skid_data;
  logic              skid_valid;
  logic              accept, deliver;
  logic              load_out_in, load_out_skid, load_skid;

  assign accept    = in_valid && in_ready;
  assign deliver   = out_valid && out_ready;
  assign occupancy = state;

  // Next-state and load-enable decode; flush overrides every handshake.
  always_comb begin
    state_next    = state;
    load_out_in   = 1'b0;
    load_out_skid = 1'b0;
    load_skid     = 1'b0;
    if (flush) begin
      state_next = EMPTY;
    end else begin
      unique case (state)
        EMPTY: begin
          if (accept) begin
            load_out_in = 1'b1;
            state_next  = BUSY;
          end
        end
        BUSY: begin
          if (accept && deliver) begin
            load_out_in = 1'b1;
          end else if (accept) begin
            load_skid  = 1'b1;
            state_next = FULL;
          end else if (deliver) begin
            state_next = EMPTY;
          end
        end
        FULL: begin
          // in_ready is low here, so only a deliver can happen.
          if (deliver) begin
            load_out_skid = 1'b1;
            state_next    = BUSY;
          end
        end
        default: state_next = EMPTY;
      endcase
    end
  end

  // State plus the registered handshake flags, all derived from the next state.
  always_ff @(negedge clk or posedge rst) begin
    if (rst) begin
      state      <= EMPTY;
      out_valid  <= 1'b0;
      skid_valid <= 1'b0;
      in_ready   <= 1'b1;
    end else begin
      state      <= state_next;
      out_valid  <= (state_next != EMPTY);
      skid_valid <= (state_next == FULL);
      in_ready   <= (state_next != FULL);
    end
  end

  // Payload registers; they keep stale contents when invalid or flushed.
  always_ff @(negedge clk or posedge rst) begin
    if (rst) begin
      out_data  <= '0;
      skid_data <= '0;
    end else begin
      if (load_out_in) begin
        out_data <= in_data;
      end else if (load_out_skid) begin
        out_data <= skid_data;
      end
      if (load_skid) begin
        skid_data <= in_data;
      end
    end
  end

`ifdef PIPE_STAGE_PERF_EN
  // Saturating stall/bubble counters; only reset clears them, flush does not.
  always_ff @(negedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt  <= '0;
      bubble_cnt <= '0;
    end else begin
      if (out_valid && !out_ready && (stall_cnt != {CNT_W{1'b1}})) begin
        stall_cnt <= stall_cnt + 1'b1;
      end
      if (!out_valid && (bubble_cnt != {CNT_W{1'b1}})) begin
        bubble_cnt <= bubble_cnt + 1'b1;
      end
    end
  end
`endif

  // skid_valid mirrors state == FULL; kept as an explicit flag for debug visibility.
  logic unused_skid_valid;
  assign unused_skid_valid = skid_valid;

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Directed testbench for pipe_stage_skid: streaming, back-pressure with skid,
// flush in FULL, asynchronous reset mid-stream and (with PIPE_STAGE_PERF_EN)
// the saturating performance counters.
module tb_pipe_stage_skid;

  localparam int DATA_W = 32;
  localparam int CNT_W  = 4;

  logic              clk = 1'b0;
  logic              rst;
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic              flush;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
  logic [1:0]        occupancy;
`ifdef PIPE_STAGE_PERF_EN
  logic [CNT_W-1:0]  stall_cnt;
  logic [CNT_W-1:0]  bubble_cnt;
`endif

  int compared   = 0;
  int mismatched = 0;

  pipe_stage_skid #(.DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .flush     (flush),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .occupancy (occupancy)
`ifdef PIPE_STAGE_PERF_EN
    ,
    .stall_cnt (stall_cnt),
    .bubble_cnt(bubble_cnt)
`endif
  );

  always #5 clk = ~clk;

  // Advance past one active (falling) edge and settle.
  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp)
      $display("ok   %s obs=%h exp=%h", tag, obs, exp);
    else begin
      mismatched++;
      $error("FAIL %s obs=%h exp=%h", tag, obs, exp);
    end
  endtask

  // Checks the handshake-visible state in one go.
  task automatic chk_state(input string tag, input logic ov, input logic ir,
                           input logic [1:0] occ);
    chk({tag, ".out_valid"}, {31'd0, out_valid}, {31'd0, ov});
    chk({tag, ".in_ready"},  {31'd0, in_ready},  {31'd0, ir});
    chk({tag, ".occupancy"}, {30'd0, occupancy}, {30'd0, occ});
  endtask

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_data   = '0;
    flush     = 1'b0;
    out_ready = 1'b0;
    #3;
    chk_state("reset", 1'b0, 1'b1, 2'd0);
    chk("reset.out_data", out_data, 32'h0);
    @(posedge clk);
    rst = 1'b0;

    // Idle three edges after reset.
    tick(); tick(); tick();
    chk_state("idle", 1'b0, 1'b1, 2'd0);
`ifdef PIPE_STAGE_PERF_EN
    chk("idle.bubble_cnt", {28'd0, bubble_cnt}, 32'd3);
    chk("idle.stall_cnt",  {28'd0, stall_cnt},  32'd0);
`endif

    // Streaming with out_ready high.
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_data   = 32'h11; tick();
    chk_state("stream11", 1'b1, 1'b1, 2'd1);
    chk("stream11.out_data", out_data, 32'h11);
    in_data   = 32'h22; tick();
    chk_state("stream22", 1'b1, 1'b1, 2'd1);
    chk("stream22.out_data", out_data, 32'h22);
    in_data   = 32'h33; tick();
    chk_state("stream33", 1'b1, 1'b1, 2'd1);
    chk("stream33.out_data", out_data, 32'h33);
    in_valid  = 1'b0; tick();
    chk_state("drain", 1'b0, 1'b1, 2'd0);
    chk("drain.out_data_held", out_data, 32'h33);

    // Back-pressure: A, B absorbed, C held upstream.
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = 32'hA; tick();
    chk_state("bpA", 1'b1, 1'b1, 2'd1);
    chk("bpA.out_data", out_data, 32'hA);
    in_data   = 32'hB; tick();
    chk_state("bpB", 1'b1, 1'b0, 2'd2);
    chk("bpB.out_data", out_data, 32'hA);
    in_data   = 32'hC; tick();
    chk_state("bpC_held", 1'b1, 1'b0, 2'd2);
    chk("bpC_held.out_data", out_data, 32'hA);
    out_ready = 1'b1; tick();
    chk_state("relB", 1'b1, 1'b1, 2'd1);
    chk("relB.out_data", out_data, 32'hB);
    tick();
    chk_state("relC", 1'b1, 1'b1, 2'd1);
    chk("relC.out_data", out_data, 32'hC);
    in_valid  = 1'b0; tick();
    chk_state("relEmpty", 1'b0, 1'b1, 2'd0);

    // Flush while FULL, with a concurrent offer of 0xD.
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = 32'hA; tick();
    in_data   = 32'hB; tick();
    chk_state("flFull", 1'b1, 1'b0, 2'd2);
    flush     = 1'b1;
    in_data   = 32'hD; tick();
    chk_state("flush", 1'b0, 1'b1, 2'd0);
    flush     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b1; tick();
    chk_state("postFlush", 1'b0, 1'b1, 2'd0);

    // Hold one payload stalled for 20 edges.
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = 32'h5A; tick();
    in_valid  = 1'b0;
    for (int i = 0; i < 20; i++) tick();
    chk_state("stall", 1'b1, 1'b1, 2'd1);
    chk("stall.out_data", out_data, 32'h5A);
`ifdef PIPE_STAGE_PERF_EN
    chk("stall.stall_cnt", {28'd0, stall_cnt}, 32'd15);
`endif

    // Asynchronous reset between edges while BUSY.
    @(posedge clk);
    rst = 1'b1;
    #1;
    chk_state("arst", 1'b0, 1'b1, 2'd0);
    chk("arst.out_data", out_data, 32'h0);
`ifdef PIPE_STAGE_PERF_EN
    chk("arst.stall_cnt", {28'd0, stall_cnt}, 32'd0);
`endif
    @(posedge clk);
    rst = 1'b0;
    tick();
    chk_state("afterRst", 1'b0, 1'b1, 2'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
